philo_waiter: RTL and testbench
===============================

Name: philo_waiter

Overview:
- Central fork arbiter ("waiter") for a ring of N philosopher seats; seat i shares one fork with each ring neighbour, (i-1) mod N and (i+1) mod N.
- Grants eating permission so that two adjacent seats never eat at the same time.
- Fairness comes from a rotating priority pointer, a bounded eating time and an aging override that prevents starvation.
- Sits beside the philosopher ring: each philosopher raises req when HUNGRY and treats grant as permission to enter EATING.

Parameters:
N, 8, number of seats in the ring (>=3)
MAX_EAT, 4, maximum consecutive cycles a seat may hold a grant before forced release (>=1)
AGE_LIMIT, 6, wait cycles after which a requesting seat becomes urgent (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  level; seat i is hungry and wants forks
release  input  N  one-cycle pulse; seat i finished eating
grant  output  N  registered; seat i currently holds both forks (EAT)
preempt  output  N  registered one-cycle pulse; seat i's grant was withdrawn by timeout
urgent  output  N  registered; seat i's wait counter has reached AGE_LIMIT

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant, preempt and urgent are 0.
  - Priority pointer ptr is 0.
  - All eat_cnt and wait_cnt are 0.
  - Reset mid-eat drops every grant immediately. After reset deassertion the first edge performs a normal scan.
- Seat state is EAT when grant[i]=1; otherwise the seat is free.
- Eligibility: seat j is eligible at edge t when req[j]=1, grant[j]=0 and grant of both neighbours is 0 (current registered values).
  - A neighbour that is releasing this same cycle still blocks. Its forks free one cycle later.
- Urgency blocking: an eligible non-urgent seat is blocked if either neighbour is urgent, requesting and not eating. This reserves the forks for the urgent seat.
- Scan: evaluate seats in order ptr, ptr+1, ..., ptr+N-1 (mod N). Grant seat j if it is eligible, not blocked, and neither neighbour was granted earlier in this same scan.
  - Adjacent urgent seats are resolved by scan order.
  - Ring wrap: seats N-1 and 0 are neighbours.
  - New grants appear on grant the cycle after the edge that samples req (latency 1).
- ptr update: if any seat is granted, ptr <= (first granted index in scan order + 1) mod N. Otherwise ptr is unchanged.
- Eating, while grant[i]=1:
  - eat_cnt[i] increments every cycle.
  - release[i]=1 -> grant[i] <= 0, eat_cnt <= 0.
  - Else if eat_cnt[i]==MAX_EAT-1 -> grant[i] <= 0, preempt[i] <= 1 for one cycle, eat_cnt <= 0.
  - Net effect: grant is high for at most MAX_EAT cycles.
  - A release arriving on the timeout cycle counts as a normal release: no preempt.
  - req dropping while eating is ignored; only release or timeout ends eating.
  - release on a non-eating seat is ignored.
- Aging:
  - wait_cnt[i] increments, saturating at AGE_LIMIT, when req[i]=1 and grant[i]=0.
  - It clears on grant or when req[i]=0.
  - urgent[i] = (wait_cnt[i]==AGE_LIMIT).
- A seat whose grant ends with req still high re-enters waiting. It is not re-grantable on the ending edge, because grant was 1 when sampled.
- Invariant: grant[i] & grant[(i+1) mod N] is never 1 for any i.
- Starvation bound: a continuously requesting seat is granted within AGE_LIMIT + 2*MAX_EAT + 2 cycles.
- Counter widths are $clog2 of the saturating maxima, with a minimum of 1 bit.

Test Plan:
- Reset, then req=8'hFF held -> after first edge grant=8'h55 (seats 0,2,4,6), ptr=1; grant stays 8'h55 for 4 cycles; preempt=8'h55 for one cycle as those grants drop. On the next edge grant=8'hAA (scan from ptr=1).
- req[3]=1 alone, release[3] pulsed on its 2nd eat cycle -> grant[3] high exactly 2 cycles, preempt[3]=0; req[2] held throughout and granted one cycle after grant[3] falls.
- Wrap: req = seats 7 and 0 only, ptr=7 -> grant[7]=1, grant[0]=0. After release[7], grant[0]=1 one cycle later.
- Aging: keep seats 2 and 4 alternating with req high and seat 3 requesting from cycle 0 -> urgent[3] rises after 6 waiting cycles. Seats 2 and 4 are then not re-granted; grant[3]=1 on the cycle after both 2 and 4 are non-eating.
- Random req/release for 10k cycles, all parameters at default -> mutual-exclusion invariant never violated; no grant longer than MAX_EAT cycles; every request served within the starvation bound.
- Assert rst_n=0 asynchronously mid-cycle while grant=8'h55 -> grant, preempt and urgent drop to 0 before the next edge. After release of reset with req=8'h01, grant becomes 8'h01 one edge later.

Source files
------------

// File: rtl/philo_waiter.sv
// philo_waiter: central fork arbiter for a ring of N philosopher seats.
//
// Seat i shares a fork with seats (i-1) mod N and (i+1) mod N. The waiter grants
// eating permission so that no two adjacent seats eat at once. Fairness comes from a
// rotating scan pointer, a bounded eating time and an aging override.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N] level, seat is hungry
//   rel      in   [N] one-cycle pulse, seat finished eating. The port cannot be called
//                 "release" because that word is reserved in SystemVerilog.
//   grant    out  [N] registered, seat holds both forks
//   preempt  out  [N] registered one-cycle pulse, grant withdrawn by timeout
//   urgent   out  [N] registered, seat's wait counter has reached AGE_LIMIT
module philo_waiter #(
    parameter int N         = 8,
    parameter int MAX_EAT   = 4,
    parameter int AGE_LIMIT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] rel,
    output logic [N-1:0] grant,
    output logic [N-1:0] preempt,
    output logic [N-1:0] urgent
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = (MAX_EAT > 1) ? $clog2(MAX_EAT) : 1;
    localparam int WW = ($clog2(AGE_LIMIT + 1) > 0) ? $clog2(AGE_LIMIT + 1) : 1;

    logic [N-1:0]         grant_q, grant_d;
    logic [N-1:0]         preempt_q, preempt_d;
    logic [N-1:0]         urgent_q, urgent_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [N-1:0][EW-1:0] eat_q, eat_d;
    logic [N-1:0][WW-1:0] wait_q, wait_d;

    // Rotated neighbour views: *_l[i] is seat (i-1) mod N, *_r[i] is seat (i+1) mod N.
    logic [N-1:0] grant_l, grant_r;
    logic [N-1:0] contend, contend_l, contend_r;
    logic [N-1:0] eligible, cand, new_grant;

    assign grant_l = {grant_q[N-2:0], grant_q[N-1]};
    assign grant_r = {grant_q[0], grant_q[N-1:1]};

    // A seat eats only when both forks are free as currently registered; a neighbour
    // releasing this cycle still holds its fork until the next edge.
    assign eligible = req & ~grant_q & ~grant_l & ~grant_r;

    // Hungry urgent seats reserve their forks against non-urgent neighbours.
    assign contend   = urgent_q & req & ~grant_q;
    assign contend_l = {contend[N-2:0], contend[N-1]};
    assign contend_r = {contend[0], contend[N-1:1]};
    assign cand      = eligible & (urgent_q | ~(contend_l | contend_r));

    // Priority scan from ptr; a seat loses if a neighbour already won earlier in the scan.
    int            scan_pos;
    logic [PW-1:0] idx, lft, rgt;
    logic          found;

    always_comb begin
        new_grant = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        scan_pos  = 0;
        idx       = '0;
        lft       = '0;
        rgt       = '0;
        for (int k = 0; k < N; k++) begin
            scan_pos = int'(ptr_q) + k;
            if (scan_pos >= N) begin
                scan_pos = scan_pos - N;
            end
            idx = PW'(scan_pos);
            lft = (idx == '0) ? PW'(N - 1) : idx - PW'(1);
            rgt = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
            if (cand[idx] && !new_grant[lft] && !new_grant[rgt]) begin
                new_grant[idx] = 1'b1;
                if (!found) begin
                    found = 1'b1;
                    ptr_d = rgt;
                end
            end
        end
    end

    // Per-seat eating timer and aging counter.
    always_comb begin
        grant_d   = grant_q;
        preempt_d = '0;
        urgent_d  = '0;
        eat_d     = eat_q;
        wait_d    = wait_q;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                if (rel[i]) begin
                    grant_d[i] = 1'b0;
                    eat_d[i]   = '0;
                end else if (eat_q[i] == EW'(MAX_EAT - 1)) begin
                    grant_d[i]   = 1'b0;
                    preempt_d[i] = 1'b1;
                    eat_d[i]     = '0;
                end else begin
                    eat_d[i] = eat_q[i] + EW'(1);
                end
            end else if (new_grant[i]) begin
                grant_d[i] = 1'b1;
                eat_d[i]   = '0;
            end

            if (grant_q[i] || new_grant[i] || !req[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WW'(AGE_LIMIT)) begin
                wait_d[i] = wait_q[i] + WW'(1);
            end
            urgent_d[i] = (wait_d[i] == WW'(AGE_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            preempt_q <= '0;
            urgent_q  <= '0;
            ptr_q     <= '0;
            eat_q     <= '0;
            wait_q    <= '0;
        end else begin
            grant_q   <= grant_d;
            preempt_q <= preempt_d;
            urgent_q  <= urgent_d;
            ptr_q     <= ptr_d;
            eat_q     <= eat_d;
            wait_q    <= wait_d;
        end
    end

    assign grant   = grant_q;
    assign preempt = preempt_q;
    assign urgent  = urgent_q;

endmodule

// File: tb/tb_philo_waiter.sv
// Testbench for philo_waiter: directed vector tables fed through a scoreboard queue,
// a constrained-random run with protocol property checks, and an async reset sequence.
module tb_philo_waiter;
    localparam int N         = 8;
    localparam int MAX_EAT   = 4;
    localparam int AGE_LIMIT = 6;
    localparam int BOUND     = AGE_LIMIT + 2 * MAX_EAT + 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req, rel;
    logic [N-1:0] grant, preempt, urgent;

    philo_waiter #(
        .N         (N),
        .MAX_EAT   (MAX_EAT),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .grant   (grant),
        .preempt (preempt),
        .urgent  (urgent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] rel;
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] u;
    } vec_t;

    vec_t             tbl[$];
    logic [3*N-1:0]   sb[$];
    logic [3*N-1:0]   want;
    int               checks;
    int               errors;
    logic [N-1:0]     nreq, nrel;
    int               eat_run[N];
    int               wait_run[N];
    int               worst_eat, worst_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, limit %0d", name, act, lim);
        end
    endtask

    task automatic add(input logic [N-1:0] rq, input logic [N-1:0] rl, input logic [N-1:0] g,
                       input logic [N-1:0] p, input logic [N-1:0] u);
        tbl.push_back({rq, rl, g, p, u});
    endtask

    task automatic reset_dut();
        req   = '0;
        rel   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Each row: inputs held through one edge, expected outputs just after that edge.
    task automatic run_table(input string name);
        for (int k = 0; k < tbl.size(); k++) begin
            req = tbl[k].req;
            rel = tbl[k].rel;
            sb.push_back({tbl[k].g, tbl[k].p, tbl[k].u});
            @(posedge clk);
            #1;
            want = sb.pop_front();
            check($sformatf("%s[%0d]", name, k), 32'({grant, preempt, urgent}), 32'(want));
        end
        tbl.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        reset_dut();
        check("reset_state", 32'({grant, preempt, urgent}), 32'h0);

        // All seats hungry: evens first, timeout, then odds from ptr=1, then evens from ptr=2
        for (int k = 0; k < 4; k++) add(8'hFF, 8'h00, 8'h55, 8'h00, 8'h00);
        add(8'hFF, 8'h00, 8'h00, 8'h55, 8'h00);
        for (int k = 0; k < 4; k++) add(8'hFF, 8'h00, 8'hAA, 8'h00, 8'h00);
        add(8'hFF, 8'h00, 8'h00, 8'hAA, 8'h00);
        add(8'hFF, 8'h00, 8'h55, 8'h00, 8'h00);
        run_table("allreq");

        // Early release of seat 3; neighbour 2 gets forks one cycle after grant[3] falls
        reset_dut();
        add(8'h08, 8'h00, 8'h08, 8'h00, 8'h00);
        add(8'h0C, 8'h00, 8'h08, 8'h00, 8'h00);
        add(8'h04, 8'h08, 8'h00, 8'h00, 8'h00);
        add(8'h04, 8'h00, 8'h04, 8'h00, 8'h00);
        run_table("release");

        // Ring wrap: seat 6 moves ptr to 7, then seats 7 and 0 contend
        reset_dut();
        add(8'h40, 8'h00, 8'h40, 8'h00, 8'h00);
        add(8'h00, 8'h40, 8'h00, 8'h00, 8'h00);
        add(8'h81, 8'h00, 8'h80, 8'h00, 8'h00);
        add(8'h81, 8'h80, 8'h00, 8'h00, 8'h00);
        add(8'h01, 8'h00, 8'h01, 8'h00, 8'h00);
        run_table("wrap");

        // Aging: seats 2 and 4 overlap their meals, seat 3 turns urgent and wins
        reset_dut();
        add(8'h1C, 8'h00, 8'h14, 8'h00, 8'h00);
        add(8'h1C, 8'h04, 8'h10, 8'h00, 8'h00);
        add(8'h1C, 8'h00, 8'h14, 8'h00, 8'h00);
        add(8'h1C, 8'h00, 8'h14, 8'h00, 8'h00);
        add(8'h1C, 8'h00, 8'h04, 8'h10, 8'h00);
        add(8'h1C, 8'h00, 8'h14, 8'h00, 8'h08);
        add(8'h1C, 8'h00, 8'h10, 8'h04, 8'h08);
        add(8'h1C, 8'h00, 8'h10, 8'h00, 8'h08);
        add(8'h1C, 8'h00, 8'h10, 8'h00, 8'h08);
        add(8'h1C, 8'h00, 8'h00, 8'h10, 8'h08);
        add(8'h1C, 8'h00, 8'h08, 8'h00, 8'h00);
        run_table("aging");

        // Random traffic: hungry seats stay hungry until served, eaters release at random
        reset_dut();
        for (int i = 0; i < N; i++) begin
            eat_run[i]  = 0;
            wait_run[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    nreq[i] = 1'($urandom_range(0, 1));
                    nrel[i] = ($urandom_range(0, 2) == 0);
                end else begin
                    nreq[i] = req[i] | ($urandom_range(0, 1) == 1);
                    nrel[i] = ($urandom_range(0, 7) == 0);
                end
            end
            req = nreq;
            rel = nrel;
            @(posedge clk);
            #1;
            worst_eat  = 0;
            worst_wait = 0;
            for (int i = 0; i < N; i++) begin
                eat_run[i]  = grant[i] ? eat_run[i] + 1 : 0;
                wait_run[i] = (nreq[i] && !grant[i]) ? wait_run[i] + 1 : 0;
                if (eat_run[i] > worst_eat) worst_eat = eat_run[i];
                if (wait_run[i] > worst_wait) worst_wait = wait_run[i];
            end
            check($sformatf("mutex@%0d", c), 32'(grant & {grant[0], grant[N-1:1]}), 32'h0);
            check_le($sformatf("eat_len@%0d", c), worst_eat, MAX_EAT);
            check_le($sformatf("starve@%0d", c), worst_wait, BOUND);
        end

        // Asynchronous reset in the middle of a meal
        reset_dut();
        req = 8'hFF;
        rel = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("async_pre", 32'(grant), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_drop", 32'({grant, preempt, urgent}), 32'h0);
        #2;
        req   = 8'h01;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_after", 32'(grant), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
